instr_encoder: RTL and testbench

- Inverse of the immediate generator: packs opcode class, register indices and a signed immediate into a 32-bit RV32I instruction word.
- Writes each encoded word sequentially into instruction memory.
- Used by the testbench/boot loader to fill instruction memory before the datapath runs.
- Immediate scaling mirrors the datapath decoder:
  - lw/sw take word offsets.
  - Branch takes halfword offsets.
  - addi takes a raw value.

---
 rtl/instr_pkg.sv | 32 +++
 rtl/instr_pack.sv | 67 ++++++
 rtl/instr_encoder.sv | 139 +++++++++++++
 tb/tb_instr_encoder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the operation selector, the major opcodes and funct3 values the
// encoder emits, and the encoder FSM state type.
package instr_pkg;

    // Operation class presented on the 'op' field of a bundle.
    typedef enum logic [1:0] {
        OP_LW     = 2'd0,
        OP_SW     = 2'd1,
        OP_ADDI   = 2'd2,
        OP_BRANCH = 2'd3
    } op_e;

    // RV32I major opcodes.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values forced for word loads/stores and addi.
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;

    // Encoder sequencing states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2,
        S_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns an operation class, register indices and a
// signed immediate into one 32-bit RV32I instruction word, and reports
// whether the immediate is representable.
// Ports:
//   op       operation class (op_e encoding)
//   rd       destination register (LW, ADDI)
//   rs1      source / base register
//   rs2      second source (SW, BRANCH)
//   funct3   branch condition (BRANCH only)
//   imm      signed immediate: word offset, raw value or halfword offset
//   word     encoded instruction
//   in_range immediate fits the instruction format
module instr_pack
    import instr_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        in_range
);

    logic [11:0] boff;
    logic [11:0] h;
    logic        fits12;
    logic        fits10;

    // Word offsets become byte offsets by shifting left two places; only
    // the low 12 bits are encoded, so imm must be a sign-extended 10-bit
    // value for the scaled offset to be exact.
    assign boff   = {imm[9:0], 2'b00};
    assign h      = imm[11:0];
    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits10 = (imm[31:9]  == {23{imm[9]}});

    always_comb begin
        word     = 32'd0;
        in_range = 1'b0;
        case (op_e'(op))
            OP_LW: begin
                word     = {boff, rs1, F3_WORD, rd, OPC_LOAD};
                in_range = fits10;
            end
            OP_SW: begin
                word     = {boff[11:5], rs2, rs1, F3_WORD, boff[4:0], OPC_STORE};
                in_range = fits10;
            end
            OP_ADDI: begin
                word     = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
                in_range = fits12;
            end
            OP_BRANCH: begin
                // Halfword offset h is the byte offset's bits [12:1].
                word     = {h[11], h[9:4], rs2, rs1, funct3, h[3:0], h[10], OPC_BRANCH};
                in_range = fits12;
            end
            default: begin
                word     = 32'd0;
                in_range = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory filler: accepts field bundles, encodes each into an
// RV32I word and writes it to the next sequential memory address.
// Bundles with unrepresentable immediates are dropped and counted.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   restart            rewind write pointer and clear err_count (IDLE only)
//   in_valid/in_ready  bundle handshake
//   op,rd,rs1,rs2,funct3,imm  field bundle
//   mem_we/mem_addr/mem_wdata instruction-memory write port
//   full               every memory word has been written
//   err, err_count     dropped-bundle pulse and saturating count
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          full,
    output logic          err,
    output logic [7:0]    err_count
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_e      state;
    logic [AW:0] ptr;
    logic [AW:0] ptr_inc;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [2:0]  funct3_q;
    logic [31:0] imm_q;
    logic [31:0] word_q;
    logic [31:0] word;
    logic        in_range;

    // The pointer is one bit wider than the address so it can hold DEPTH.
    assign ptr_inc = ptr + 1'b1;

    instr_pack u_pack (
        .op       (op_q),
        .rd       (rd_q),
        .rs1      (rs1_q),
        .rs2      (rs2_q),
        .funct3   (funct3_q),
        .imm      (imm_q),
        .word     (word),
        .in_range (in_range)
    );

    // Sequencer: IDLE accepts, ENC registers the encoding and range verdict,
    // WR or ERR schedules the one-cycle output pulse. Outputs are registered,
    // so the pulse appears in the cycle after the WR/ERR state, and a reset
    // landing during WR/ERR suppresses it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            full      <= 1'b0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            err       <= 1'b0;
            err_count <= 8'd0;
            word_q    <= 32'd0;
            op_q      <= 2'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            funct3_q  <= 3'd0;
            imm_q     <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (restart) begin
                        ptr       <= '0;
                        full      <= 1'b0;
                        err_count <= 8'd0;
                        in_ready  <= 1'b1;
                    end else if (in_valid && in_ready) begin
                        op_q     <= op;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        funct3_q <= funct3;
                        imm_q    <= imm;
                        in_ready <= 1'b0;
                        state    <= S_ENC;
                    end else begin
                        in_ready <= !full;
                    end
                end
                S_ENC: begin
                    word_q <= word;
                    state  <= in_range ? S_WR : S_ERR;
                end
                S_WR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr[AW-1:0];
                    mem_wdata <= word_q;
                    ptr       <= ptr_inc;
                    full      <= (ptr_inc == DEPTH_W);
                    in_ready  <= (ptr_inc != DEPTH_W);
                    state     <= S_IDLE;
                end
                S_ERR: begin
                    err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    in_ready <= !full;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder, built with a 4-word
// memory so the full/restart behaviour is reachable quickly.
module tb_instr_encoder;
    import instr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        full;
    logic        err;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .full      (full),
        .err       (err),
        .err_count (err_count)
    );

    // Advance one clock and sample just after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        step;
        restart = 1'b0;
    endtask

    // Presents one bundle from IDLE and reports what the write port did:
    // 'early' is any write/err seen before edge N+2, the rest is sampled
    // in the cycle after edge N+2.
    task automatic run_bundle(input logic [1:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im,
                              output logic early, output logic we, output logic e,
                              output logic [1:0] a, output logic [31:0] w);
        op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        early = mem_we | err;
        step;
        early = early | mem_we | err;
        step;
        we = mem_we; e = err; a = mem_addr; w = mem_wdata;
    endtask

    task automatic test_reset;
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0;
        op = 2'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; imm = 32'd0;
        step;
        step;
        vectors++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 2'd0 || mem_wdata !== 32'd0 ||
            full !== 1'b0 || err !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: rdy=%b we=%b addr=%0d wdata=%h full=%b err=%b cnt=%0d, want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, full, err, err_count);
        end
        reset = 1'b0;
        step;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_addi;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        // rs2/funct3 carry junk that ADDI must ignore.
        run_bundle(OP_ADDI, 5'd5, 5'd0, 5'd31, 3'b111, 32'd7, early, we, e, a, w);
        vectors++;
        if (early !== 1'b0 || we !== 1'b1 || e !== 1'b0 || a !== 2'd0 || w !== 32'h00700293) begin
            miscompares++;
            $display("[TB] FAIL addi: early=%b we=%b err=%b addr=%0d data=%h, want 0 1 0 0 00700293",
                     early, we, e, a, w);
        end
        step;
        vectors++;
        if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL addi_one_cycle: we=%b rdy=%b, want we=0 rdy=1", mem_we, in_ready);
        end
    endtask

    task automatic test_lw_sw;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        logic signed [31:0] dec;
        pulse_restart;
        run_bundle(OP_LW, 5'd6, 5'd1, 5'd9, 3'b101, 32'd2, early, we, e, a, w);
        dec = $signed({{20{w[31]}}, w[31:20]}) >>> 2;
        vectors++;
        if (early !== 1'b0 || we !== 1'b1 || a !== 2'd0 || w !== 32'h0080A303 || dec !== 32'sd2) begin
            miscompares++;
            $display("[TB] FAIL lw: we=%b addr=%0d data=%h decoded=%0d, want we=1 addr=0 0080A303 2",
                     we, a, w, dec);
        end
        run_bundle(OP_SW, 5'd17, 5'd2, 5'd7, 3'b000, 32'hFFFFFFFF, early, we, e, a, w);
        dec = $signed({{20{w[31]}}, w[31:25], w[11:7]}) >>> 2;
        vectors++;
        if (early !== 1'b0 || we !== 1'b1 || a !== 2'd1 || w !== 32'hFE712E23 || dec !== -32'sd1) begin
            miscompares++;
            $display("[TB] FAIL sw: we=%b addr=%0d data=%h decoded=%0d, want we=1 addr=1 FE712E23 -1",
                     we, a, w, dec);
        end
    endtask

    task automatic test_branch;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        run_bundle(OP_BRANCH, 5'd30, 5'd1, 5'd2, 3'b000, 32'hFFFFFFFC, early, we, e, a, w);
        vectors++;
        if (early !== 1'b0 || we !== 1'b1 || a !== 2'd2 || w !== 32'hFE208CE3) begin
            miscompares++;
            $display("[TB] FAIL branch: we=%b addr=%0d data=%h, want we=1 addr=2 FE208CE3", we, a, w);
        end
    endtask

    task automatic test_errors;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        pulse_restart;
        run_bundle(OP_ADDI, 5'd5, 5'd0, 5'd0, 3'b000, 32'd2048, early, we, e, a, w);
        vectors++;
        if (early !== 1'b0 || e !== 1'b1 || we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_addi_2048: early=%b err=%b we=%b, want 0 1 0", early, e, we);
        end
        run_bundle(OP_LW, 5'd5, 5'd0, 5'd0, 3'b000, 32'd512, early, we, e, a, w);
        vectors++;
        if (early !== 1'b0 || e !== 1'b1 || we !== 1'b0 || err_count !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL err_lw_512: err=%b we=%b count=%0d, want err=1 we=0 count=2",
                     e, we, err_count);
        end
        run_bundle(OP_ADDI, 5'd5, 5'd0, 5'd0, 3'b000, 32'd7, early, we, e, a, w);
        vectors++;
        if (we !== 1'b1 || e !== 1'b0 || a !== 2'd0 || w !== 32'h00700293) begin
            miscompares++;
            $display("[TB] FAIL err_then_write: we=%b err=%b addr=%0d data=%h, want 1 0 0 00700293",
                     we, e, a, w);
        end
    endtask

    task automatic test_boundaries;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        logic [1:0]  bop  [4] = '{OP_ADDI, OP_ADDI, OP_LW, OP_LW};
        logic [31:0] bimm [4] = '{32'hFFFFF800, 32'd2047, 32'hFFFFFE00, 32'd511};
        logic [4:0]  brd  [4] = '{5'd1, 5'd3, 5'd1, 5'd1};
        logic [4:0]  brs  [4] = '{5'd2, 5'd4, 5'd2, 5'd2};
        logic [31:0] bexp [4] = '{32'h80010093, 32'h7FF20193, 32'h80012083, 32'h7FC12083};
        pulse_restart;
        // Just outside each range, plus an immediate whose upper bits are not a sign extension.
        run_bundle(OP_SW, 5'd0, 5'd1, 5'd2, 3'b000, 32'hFFFFFDFF, early, we, e, a, w);
        run_bundle(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 32'd2048, early, we, e, a, w);
        run_bundle(OP_ADDI, 5'd1, 5'd1, 5'd0, 3'b000, 32'h00010007, early, we, e, a, w);
        vectors++;
        if (e !== 1'b1 || we !== 1'b0 || err_count !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL out_of_range: err=%b we=%b count=%0d, want err=1 we=0 count=3",
                     e, we, err_count);
        end
        for (int i = 0; i < 4; i++) begin
            run_bundle(bop[i], brd[i], brs[i], 5'd0, 3'b000, bimm[i], early, we, e, a, w);
            vectors++;
            if (we !== 1'b1 || e !== 1'b0 || a !== 2'(i) || w !== bexp[i]) begin
                miscompares++;
                $display("[TB] FAIL edge_imm_%0d: we=%b err=%b addr=%0d data=%h, want 1 0 %0d %h",
                         i, we, e, a, w, i, bexp[i]);
            end
        end
    endtask

    task automatic test_full;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        logic seen_we;
        logic seen_rdy;
        pulse_restart;
        for (int i = 0; i < 4; i++) begin
            run_bundle(OP_ADDI, 5'(i + 1), 5'd0, 5'd0, 3'b000, 32'(i), early, we, e, a, w);
            vectors++;
            if (we !== 1'b1 || a !== 2'(i) || w !== {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011}) begin
                miscompares++;
                $display("[TB] FAIL fill_%0d: we=%b addr=%0d data=%h, want we=1 addr=%0d", i, we, a, w, i);
            end
        end
        vectors++;
        if (full !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_flag: full=%b rdy=%b, want full=1 rdy=0", full, in_ready);
        end
        op = OP_ADDI; rd = 5'd9; rs1 = 5'd0; imm = 32'd1;
        in_valid = 1'b1;
        seen_we = 1'b0;
        seen_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            seen_we  = seen_we | mem_we | err;
            seen_rdy = seen_rdy | in_ready;
        end
        in_valid = 1'b0;
        vectors++;
        if (seen_we !== 1'b0 || seen_rdy !== 1'b0 || full !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fifth_ignored: wrote=%b rdy=%b full=%b, want 0 0 1", seen_we, seen_rdy, full);
        end
        pulse_restart;
        vectors++;
        if (full !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL restart_clears_full: full=%b rdy=%b, want full=0 rdy=1", full, in_ready);
        end
        run_bundle(OP_ADDI, 5'd5, 5'd0, 5'd0, 3'b000, 32'd7, early, we, e, a, w);
        vectors++;
        if (we !== 1'b1 || a !== 2'd0 || w !== 32'h00700293) begin
            miscompares++;
            $display("[TB] FAIL after_restart: we=%b addr=%0d data=%h, want 1 0 00700293", we, a, w);
        end
    endtask

    task automatic test_restart_with_valid;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        logic seen;
        op = OP_ADDI; rd = 5'd8; rs1 = 5'd0; imm = 32'd3;
        restart = 1'b1;
        in_valid = 1'b1;
        step;
        restart = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL restart_wins_ready: rdy=%b, want 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            seen = seen | mem_we | err;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL restart_wins_nowrite: wrote=%b, want 0", seen);
        end
        run_bundle(OP_ADDI, 5'd5, 5'd0, 5'd0, 3'b000, 32'd7, early, we, e, a, w);
        vectors++;
        if (we !== 1'b1 || a !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL restart_wins_ptr: we=%b addr=%0d, want 1 0", we, a);
        end
    endtask

    task automatic test_reset_mid_wr;
        logic early, we, e;
        logic [1:0] a;
        logic [31:0] w;
        op = OP_ADDI; rd = 5'd4; rs1 = 5'd4; imm = 32'd4;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        reset = 1'b1;
        step;
        vectors++;
        if (mem_we !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_wr: we=%b err=%b rdy=%b, want 0 0 0", mem_we, err, in_ready);
        end
        reset = 1'b0;
        step;
        run_bundle(OP_ADDI, 5'd5, 5'd0, 5'd0, 3'b000, 32'd7, early, we, e, a, w);
        vectors++;
        if (we !== 1'b1 || a !== 2'd0 || w !== 32'h00700293) begin
            miscompares++;
            $display("[TB] FAIL reset_in_wr_ptr: we=%b addr=%0d data=%h, want 1 0 00700293", we, a, w);
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_lw_sw;
        test_branch;
        test_errors;
        test_boundaries;
        test_full;
        test_restart_with_valid;
        test_reset_mid_wr;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
